// File: rtl/rnn_input_feeder_pkg.sv
// rnn_input_feeder_pkg: shared widths and feeder state encoding for the RNN input stage
package rnn_input_feeder_pkg;
  localparam int RNN_XW = 32;
  localparam int RNN_BW = 8;
  localparam int RNN_TW = 11;
  typedef enum logic [1:0] {FILL, ARMED, RUN, DRAIN} feed_state_e;
endpackage

// File: rtl/rnn_input_feeder_if.sv
// rnn_input_feeder_if: byte stream in, x_t word request/serve to the RNN core
interface rnn_input_feeder_if;
  import rnn_input_feeder_pkg::*;
  logic              s_valid;
  logic [RNN_BW-1:0] s_data;
  logic              s_last;
  logic              s_ready;
  logic              ready;
  logic              busy;
  logic              i_en;
  logic [RNN_XW-1:0] idata;
  logic              underflow;
  logic [RNN_TW-1:0] words_out;
  modport master (output s_valid, s_data, s_last, busy, i_en,
                  input s_ready, ready, idata, underflow, words_out);
  modport slave (input s_valid, s_data, s_last, busy, i_en,
                 output s_ready, ready, idata, underflow, words_out);
endinterface

// File: rtl/rnn_input_feeder_fifo.sv
// rnn_sync_fifo: power-of-two synchronous FIFO with registered count; push+pop in one cycle is legal
module rnn_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int W = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [W-1:0]               wdata_i,
  input  logic                       pop_i,
  output logic [W-1:0]               rdata_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] count_q;
  logic push_ok, pop_ok;
  assign full_o = count_q == (AW+1)'(DEPTH);
  assign empty_o = count_q == '0;
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_q];
  assign pop_ok = pop_i & ~empty_o;
  assign push_ok = push_i & (~full_o | pop_ok);
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= wdata_i;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + 1'b1;
      if (pop_ok) rd_q <= rd_q + 1'b1;
      count_q <= count_q + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};
    end
  end
endmodule

// File: rtl/rnn_input_feeder.sv
// rnn_input_feeder: packs bytes into 32-bit x_t words, buffers them and serves the RNN core on i_en
module rnn_input_feeder
  import rnn_input_feeder_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PRIME = 2
) (
  input logic clk,
  input logic reset,
  rnn_input_feeder_if.slave bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  feed_state_e state_q, state_d;
  logic [1:0] lane_q;
  logic [RNN_XW-1:0] pack_q, idata_q, wdata, head;
  logic last_seen_q, underflow_q;
  logic [RNN_TW-1:0] words_q;
  logic [CW-1:0] count;
  logic full, empty, take, push, pop;
  assign bus.s_ready = (lane_q != 2'd3 && !bus.s_last) || !full;
  assign take = bus.s_valid & bus.s_ready;
  assign push = take & (lane_q == 2'd3 | bus.s_last);
  assign wdata = pack_q | (RNN_XW'(bus.s_data) << {lane_q, 3'b000});
  assign pop = (state_q == RUN) & bus.i_en & ~empty;
  assign bus.ready = (state_q == ARMED) && !bus.busy;
  assign bus.idata = idata_q;
  assign bus.underflow = underflow_q;
  assign bus.words_out = words_q;
  rnn_sync_fifo #(.DEPTH(DEPTH), .W(RNN_XW)) u_fifo (
    .clk(clk), .rst(reset), .push_i(push), .wdata_i(wdata), .pop_i(pop),
    .rdata_o(head), .count_o(count), .full_o(full), .empty_o(empty)
  );
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FILL:    if (count >= CW'(PRIME) || (last_seen_q && !empty)) state_d = ARMED;
      ARMED:   if (bus.busy) state_d = RUN;
      RUN:     if (!bus.busy) state_d = DRAIN;
      default: state_d = FILL;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FILL;
      lane_q <= '0;
      pack_q <= '0;
      last_seen_q <= 1'b0;
      idata_q <= '0;
      underflow_q <= 1'b0;
      words_q <= '0;
    end else begin
      state_q <= state_d;
      if (take) begin
        lane_q <= push ? 2'd0 : lane_q + 2'd1;
        pack_q <= push ? '0 : wdata;
      end
      // a new sequence's last byte arriving during DRAIN must not be lost
      if (take && bus.s_last) last_seen_q <= 1'b1;
      else if (state_q == DRAIN) last_seen_q <= 1'b0;
      if (pop) begin
        idata_q <= head;
        words_q <= words_q + {{(RNN_TW-1){1'b0}}, ~&words_q};
      end else if (state_q == DRAIN) words_q <= '0;
      if (state_q == RUN && bus.i_en && empty) underflow_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_rnn_input_feeder.sv
// tb_rnn_input_feeder: directed table plus hand sequences for the RNN input feeder
module tb_rnn_input_feeder;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;
  rnn_input_feeder_if bus();
  rnn_input_feeder #(.DEPTH(8), .PRIME(2)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic v; logic [7:0] d; logic l; logic b; logic e;
    logic sr; logic rdy; logic [31:0] id; logic un; logic [10:0] wo;
  } vec_t;
  vec_t tbl [24];
  function automatic vec_t mk(logic v, logic [7:0] d, logic l, logic b, logic e,
                              logic sr, logic rdy, logic [31:0] id, logic un, logic [10:0] wo);
    vec_t t;
    t.v = v; t.d = d; t.l = l; t.b = b; t.e = e;
    t.sr = sr; t.rdy = rdy; t.id = id; t.un = un; t.wo = wo;
    return t;
  endfunction
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(logic v, logic [7:0] d, logic l, logic b, logic e);
    bus.s_valid = v; bus.s_data = d; bus.s_last = l; bus.busy = b; bus.i_en = e;
  endtask
  task automatic chk_all(string tag, logic sr, logic rdy, logic [31:0] id, logic un, logic [10:0] wo);
    chk({tag, "_s_ready"}, 32'(bus.s_ready), 32'(sr));
    chk({tag, "_ready"}, 32'(bus.ready), 32'(rdy));
    chk({tag, "_idata"}, bus.idata, id);
    chk({tag, "_underflow"}, 32'(bus.underflow), 32'(un));
    chk({tag, "_words_out"}, 32'(bus.words_out), 32'(wo));
  endtask
  initial begin
    tbl[0]  = mk(1, 8'h11, 0, 0, 0, 1, 0, 32'h0, 0, 0);
    tbl[1]  = mk(1, 8'h22, 0, 0, 0, 1, 0, 32'h0, 0, 0);
    tbl[2]  = mk(1, 8'h33, 0, 0, 0, 1, 0, 32'h0, 0, 0);
    tbl[3]  = mk(1, 8'h44, 0, 0, 0, 1, 0, 32'h0, 0, 0);
    tbl[4]  = mk(1, 8'h55, 0, 0, 0, 1, 0, 32'h0, 0, 0);
    tbl[5]  = mk(1, 8'h66, 0, 0, 0, 1, 0, 32'h0, 0, 0);
    tbl[6]  = mk(1, 8'h77, 0, 0, 0, 1, 0, 32'h0, 0, 0);
    tbl[7]  = mk(1, 8'h88, 0, 0, 0, 1, 0, 32'h0, 0, 0);
    tbl[8]  = mk(0, 8'h00, 0, 0, 0, 1, 1, 32'h0, 0, 0);
    tbl[9]  = mk(0, 8'h00, 0, 1, 0, 1, 0, 32'h0, 0, 0);
    tbl[10] = mk(0, 8'h00, 0, 1, 1, 1, 0, 32'h44332211, 0, 1);
    tbl[11] = mk(0, 8'h00, 0, 1, 0, 1, 0, 32'h44332211, 0, 1);
    tbl[12] = mk(0, 8'h00, 0, 1, 1, 1, 0, 32'h88776655, 0, 2);
    tbl[13] = mk(0, 8'h00, 0, 1, 1, 1, 0, 32'h88776655, 1, 2);
    tbl[14] = mk(0, 8'h00, 0, 1, 0, 1, 0, 32'h88776655, 1, 2);
    tbl[15] = mk(0, 8'h00, 0, 0, 0, 1, 0, 32'h88776655, 1, 2);
    tbl[16] = mk(0, 8'h00, 0, 0, 0, 1, 0, 32'h88776655, 1, 0);
    tbl[17] = mk(1, 8'hAA, 0, 0, 0, 1, 0, 32'h88776655, 1, 0);
    tbl[18] = mk(1, 8'hBB, 1, 0, 0, 1, 0, 32'h88776655, 1, 0);
    tbl[19] = mk(0, 8'h00, 0, 0, 0, 1, 1, 32'h88776655, 1, 0);
    tbl[20] = mk(0, 8'h00, 0, 1, 0, 1, 0, 32'h88776655, 1, 0);
    tbl[21] = mk(0, 8'h00, 0, 1, 1, 1, 0, 32'h0000BBAA, 1, 1);
    tbl[22] = mk(0, 8'h00, 0, 0, 0, 1, 0, 32'h0000BBAA, 1, 1);
    tbl[23] = mk(0, 8'h00, 0, 0, 0, 1, 0, 32'h0000BBAA, 1, 0);
    drive(0, 8'h00, 0, 0, 0);
    step; step;
    reset = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      drive(1, 8'(i), 0, 0, 0);
      step;
    end
    reset = 1'b1;
    step; step;
    drive(0, 8'h00, 0, 0, 0);
    #1;
    chk_all("rst_mid", 1, 0, 32'h0, 0, 0);
    reset = 1'b0;
    for (int i = 0; i < 24; i++) begin
      drive(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].b, tbl[i].e);
      step;
      chk_all($sformatf("v%0d", i), tbl[i].sr, tbl[i].rdy, tbl[i].id, tbl[i].un, tbl[i].wo);
    end
    for (int i = 0; i < 35; i++) begin
      drive(1, 8'(i), 0, 0, 0);
      step;
    end
    drive(1, 8'd35, 0, 1, 0);
    #1;
    chk("full_ready", 32'(bus.ready), 32'(0));
    chk("full_bp", 32'(bus.s_ready), 32'(0));
    step;
    drive(1, 8'd35, 0, 1, 1);
    #1;
    chk("full_bp_run", 32'(bus.s_ready), 32'(0));
    step;
    drive(1, 8'd35, 0, 1, 0);
    #1;
    chk("full_freed", 32'(bus.s_ready), 32'(1));
    chk("full_pop_idata", bus.idata, 32'h03020100);
    chk("full_pop_words", 32'(bus.words_out), 32'd1);
    step;
    for (int w = 1; w <= 8; w++) begin
      drive(0, 8'h00, 0, 1, 1);
      step;
      chk($sformatf("drain_idata%0d", w), bus.idata,
          {8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)});
      chk($sformatf("drain_words%0d", w), 32'(bus.words_out), 32'(w + 1));
    end
    step;
    chk("under_idata", bus.idata, 32'h23222120);
    chk("under_words", 32'(bus.words_out), 32'd9);
    chk("under_flag", 32'(bus.underflow), 32'd1);
    for (int i = 0; i < 8; i++) begin
      drive(1, 8'hA0 + 8'(i), 0, 1, 0);
      step;
    end
    drive(0, 8'h00, 0, 0, 0);
    step;
    chk("turn_words_run", 32'(bus.words_out), 32'd9);
    step;
    chk("turn_words_clr", 32'(bus.words_out), 32'd0);
    chk("turn_ready_fill", 32'(bus.ready), 32'd0);
    step;
    chk("turn_rearm", 32'(bus.ready), 32'd1);
    drive(0, 8'h00, 0, 1, 0);
    step;
    drive(0, 8'h00, 0, 1, 1);
    step;
    chk("turn_idata", bus.idata, 32'hA3A2A1A0);
    chk("turn_words", 32'(bus.words_out), 32'd1);
    drive(1, 8'h5A, 0, 1, 0);
    reset = 1'b1;
    step; step;
    drive(0, 8'h00, 0, 0, 0);
    #1;
    chk_all("rst_end", 1, 0, 32'h0, 0, 0);
    reset = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
